// File: rtl/row_mod_reduce.sv
// Three-stage pipelined reduction of 128-bit row accumulators modulo the
// Goldilocks prime p = 2^64 - 2^32 + 1, with row framing check and row counter.
module row_mod_reduce #(
    parameter int unsigned ROW_LEN = 72,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_data,
    output logic              out_last,
    output logic [CNT_W-1:0]  rows_done,
    output logic              frame_err
);

    localparam int unsigned WORD_W = 64;
    localparam int unsigned HALF_W = 32;
    localparam int unsigned BEAT_W = $clog2(ROW_LEN + 1);
    localparam logic [WORD_W-1:0] P   = 64'hFFFF_FFFF_0000_0001;
    // 2^64 mod p
    localparam logic [WORD_W-1:0] EPS = 64'h0000_0000_FFFF_FFFF;

    logic                stall;
    logic                in_xfer;
    logic                out_xfer;

    logic                v1_q, v1_d, l1_q, l1_d;
    logic [WORD_W-1:0]   t0_q, t0_d;
    logic [HALF_W-1:0]   xhl_q, xhl_d;
    logic                v2_q, v2_d, l2_q, l2_d;
    logic [WORD_W-1:0]   s_q, s_d;
    logic                v3_q, v3_d, l3_q, l3_d;
    logic [WORD_W-1:0]   r_q, r_d;

    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                ferr_q, ferr_d;
    logic [CNT_W-1:0]    rows_q, rows_d;

    logic [WORD_W:0]     diff;
    logic [WORD_W-1:0]   t1;
    logic [WORD_W:0]     sum;
    logic [BEAT_W-1:0]   beat_nxt;
    logic                at_end;

    assign stall    = v3_q & ~out_ready;
    assign in_ready = ~stall;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = v3_q & out_ready;

    assign out_valid = v3_q;
    assign out_last  = l3_q;
    assign out_data  = r_q;
    assign rows_done = rows_q;
    assign frame_err = ferr_q;

    // Datapath: fold 2^96 as -1 in stage 1, 2^64 as 2^32-1 in stage 2, canonicalise in stage 3
    always_comb begin
        diff = {1'b0, in_data[63:0]} - {33'd0, in_data[127:96]};
        t0_d = diff[WORD_W] ? (diff[WORD_W-1:0] - EPS) : diff[WORD_W-1:0];
        xhl_d = in_data[95:64];
        v1_d  = in_valid;
        l1_d  = in_last;

        t1  = {xhl_q, 32'd0} - {32'd0, xhl_q};
        sum = {1'b0, t0_q} + {1'b0, t1};
        s_d = sum[WORD_W] ? (sum[WORD_W-1:0] + EPS) : sum[WORD_W-1:0];
        v2_d = v1_q;
        l2_d = l1_q;

        r_d  = (s_q >= P) ? (s_q - P) : s_q;
        v3_d = v2_q;
        l3_d = l2_q;
    end

    // Row framing: beat ROW_LEN and in_last must coincide
    always_comb begin
        beat_d   = beat_q;
        ferr_d   = ferr_q;
        rows_d   = rows_q;
        beat_nxt = beat_q + BEAT_W'(1);
        at_end   = (beat_nxt == BEAT_W'(ROW_LEN));
        if (in_xfer) begin
            if (in_last != at_end) begin
                ferr_d = 1'b1;
            end
            beat_d = (in_last || at_end) ? '0 : beat_nxt;
        end
        if (out_xfer && l3_q) begin
            rows_d = rows_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            l1_q   <= 1'b0;
            t0_q   <= '0;
            xhl_q  <= '0;
            v2_q   <= 1'b0;
            l2_q   <= 1'b0;
            s_q    <= '0;
            v3_q   <= 1'b0;
            l3_q   <= 1'b0;
            r_q    <= '0;
            beat_q <= '0;
            ferr_q <= 1'b0;
            rows_q <= '0;
        end else begin
            if (!stall) begin
                v1_q  <= v1_d;
                l1_q  <= l1_d;
                t0_q  <= t0_d;
                xhl_q <= xhl_d;
                v2_q  <= v2_d;
                l2_q  <= l2_d;
                s_q   <= s_d;
                v3_q  <= v3_d;
                l3_q  <= l3_d;
                r_q   <= r_d;
            end
            beat_q <= beat_d;
            ferr_q <= ferr_d;
            rows_q <= rows_d;
        end
    end

endmodule
